// File: rtl/font_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : font_arb_pkg
// Brief   : Shared constants, address type and glyph-row address helper for
//           the font ROM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package font_arb_pkg;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 8;
  localparam int GLYPH_ROWS = 16;

  typedef logic [ADDR_W-1:0] font_addr_t;

  function automatic font_addr_t glyph_row_addr(input logic [6:0] char_code,
                                                input logic [3:0] row);
    return {char_code, row};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; search starts at i_ptr and
//           wraps modulo N. Produces a one-hot grant and its index.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_grant_idx
);
  import font_arb_pkg::*;

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      // one extra bit keeps ptr+k from overflowing before the wrap
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N)) begin
        w_sum = w_sum - (PTR_W+1)'(N);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : font_rom_arbiter
// Brief   : Shares one synchronous font ROM among NUM_REQ renderers with a
//           valid/ready request side and one-hot tagged responses.
//           Build option FONT_ARB_FIXED_PRIO_EN: requester 0 has absolute
//           priority, the rest rotate over 1..NUM_REQ-1.
// Revision: 1.0 - initial release
// ============================================================================
module font_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = font_arb_pkg::ADDR_W
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]        req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [font_arb_pkg::DATA_W-1:0]  rsp_data,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [font_arb_pkg::DATA_W-1:0]  rom_data
);
  import font_arb_pkg::*;

  localparam int               PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NUM_REQ - 1);
`ifdef FONT_ARB_FIXED_PRIO_EN
  localparam logic [PTR_W-1:0] c_RST_PTR = PTR_W'(1);
`else
  localparam logic [PTR_W-1:0] c_RST_PTR = '0;
`endif

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [NUM_REQ-1:0] r_tag [0:ROM_LAT];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_arb_req;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic [PTR_W-1:0]   w_arb_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_gidx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic               w_accept;

  assign w_req = req_valid & {NUM_REQ{~Reset}};

`ifdef FONT_ARB_FIXED_PRIO_EN
  assign w_arb_req = w_req & ~NUM_REQ'(1);
`else
  assign w_arb_req = w_req;
`endif

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req       (w_arb_req),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_arb_grant),
    .o_grant_idx (w_arb_idx)
  );

  always_comb begin
    w_grant    = w_arb_grant;
    w_gidx     = w_arb_idx;
`ifdef FONT_ARB_FIXED_PRIO_EN
    if (w_req[0]) begin
      w_grant = NUM_REQ'(1);
      w_gidx  = '0;
    end
    // rotation skips requester 0, so a grant to 0 leaves the pointer alone
    if (w_gidx == '0) begin
      w_next_ptr = r_rr_ptr;
    end else if (w_gidx == c_LAST) begin
      w_next_ptr = PTR_W'(1);
    end else begin
      w_next_ptr = w_gidx + 1'b1;
    end
`else
    w_next_ptr = (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;
`endif
  end

  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_accept = |w_grant;

  // r_tag[0] marks the address now in r_rom_addr; r_tag[ROM_LAT] lines up
  // with rom_data, which is registered together with its tag on the next edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rr_ptr    <= c_RST_PTR;
      r_rom_addr  <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_rr_ptr   <= w_next_ptr;
        r_rom_addr <= w_sel_addr;
      end
      r_tag[0] <= w_grant;
      for (int i = 1; i <= ROM_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      r_rsp_valid <= r_tag[ROM_LAT];
      r_rsp_data  <= (|r_tag[ROM_LAT]) ? rom_data : '0;
    end
  end

  assign req_ready = w_grant;
  assign rom_addr  = r_rom_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
